// File: rtl/argon_pkg.sv
// argon_pkg: shared arbitration mode type and default sizing for the argon bus mux.
package argon_pkg;
  typedef enum logic {MODE_PRIORITY = 1'b0, MODE_ROUND_ROBIN = 1'b1} bus_mode_e;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_CNT_WIDTH = 8;
endpackage

// File: rtl/argon_rr_picker.sv
// argon_rr_picker: combinational winner search over the request vector.
module argon_rr_picker
  import argon_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int IW       = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [IW-1:0]       ptr_i,
  input  bus_mode_e           mode_i,
  output logic [IW-1:0]       win_o,
  output logic                any_o
);
  logic [IW-1:0] base;
  // Priority mode is a round-robin search that always starts just after the top channel.
  assign base = (mode_i == MODE_PRIORITY) ? IW'(CHANNELS - 1) : ptr_i;
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      if (!any_o && req_i[(int'(base) + k) % CHANNELS]) begin
        win_o = IW'((int'(base) + k) % CHANNELS);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/argon_bus_mux.sv
// argon_bus_mux: N-channel arbitrated bus mux with registered output slot and conflict counter.
module argon_bus_mux
  import argon_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_valid,
  input  bus_mode_e                 i_mode,
  input  logic                      i_ready,
  input  logic                      i_clear_count,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_valid,
  output logic [CHANNELS-1:0]       o_grant,
  output logic                      o_conflict,
  output logic [CNT_WIDTH-1:0]      o_conflict_count
);
  localparam int IW = $clog2(CHANNELS);
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d, conflict_q, conflict_d;
  logic [CHANNELS-1:0]  grant_q, grant_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]        ptr_q, ptr_d, win;
  logic                 any, load, capture, multi;
  argon_rr_picker #(.CHANNELS(CHANNELS)) u_pick (
    .req_i (i_valid),
    .ptr_i (ptr_q),
    .mode_i(i_mode),
    .win_o (win),
    .any_o (any)
  );
  assign load    = !valid_q || i_ready;
  assign capture = load && any;
  assign multi   = $countones(i_valid) >= 2;
  always_comb begin
    data_d     = capture ? i_data[int'(win)*WIDTH +: WIDTH] : data_q;
    valid_d    = load ? any : valid_q;
    grant_d    = capture ? CHANNELS'(1) << win : '0;
    conflict_d = capture && multi;
    ptr_d      = capture ? win : ptr_q;
    cnt_d      = i_clear_count ? '0 :
                 (conflict_d && cnt_q != '1) ? CNT_WIDTH'(cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      grant_q    <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= IW'(CHANNELS - 1);
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      grant_q    <= grant_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end
  assign o_data           = data_q;
  assign o_valid          = valid_q;
  assign o_grant          = grant_q;
  assign o_conflict       = conflict_q;
  assign o_conflict_count = cnt_q;
endmodule
